timer_bank: RTL and testbench
=============================

// Module: timer_bank
// PURPOSE
//  NUM_CH-channel programmable down-counter timer bank with per-channel interrupt
//  pending/mask and auto-reload mode. Sits on the bridge peripheral bus beside the CPU.
//  Drives per-channel IRQ lines into the CPU HWInt vector, plus an OR-reduced irq_any.
// PARAMETERS
//  NUM_CH  2   number of timer channels, 1..8
//  CNT_W   32  counter/preset width, 1..32; reads are zero-extended to 32 bits
//  AW      8   byte-address width; must be >= 4+clog2(NUM_CH)
// PORTS
//  clk     in   1       system clock
//  reset   in   1       asynchronous, active-low reset
//  addr    in   AW      byte address; [3:2] selects register, [AW-1:4] selects channel
//  we      in   1       write strobe, sampled on rising clk
//  wdata   in   32      write data
//  rdata   out  32      read data, combinational from addr
//  irq     out  NUM_CH  per-channel interrupt = pending & CTRL.IM
//  irq_any out  1       |irq
// BEHAVIOUR
//  Registers per channel, stride 0x10:
//   0x0 CTRL R/W: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), [3] IM
//   0x4 PRESET R/W; 0x8 COUNT RO (writes ignored); 0xC STATUS: [0] pending, write 1 to clear
//  - Channel index >= NUM_CH or unused bits: reads return 0, writes are ignored.
//  - Reset, asynchronous and valid mid-count: CTRL, PRESET, COUNT, pending = 0; state IDLE.
//    irq and irq_any = 0.
//  - FSM per channel: IDLE -> LOAD -> CNT -> EXPIRE.
//   IDLE: move to LOAD on the edge after EN reads 1.
//   LOAD: COUNT <= PRESET; move to CNT.
//   CNT: if COUNT==0, move to EXPIRE; otherwise COUNT-- on each tick.
//   EXPIRE: pending <= 1 on entry. Auto-reload goes to LOAD. One-shot clears EN, goes to IDLE.
//   Any state with EN==0: go to IDLE next edge. COUNT holds its value.
//  - Tick: every clk without the macro.
//  - One-shot latency: CTRL write at edge e0 -> pending=1 at edge e0+PRESET+2.
//    Auto-reload period is PRESET+3 clks. PRESET=0 expires at e0+2.
//  - A PRESET write mid-count takes effect at the next LOAD only.
//  - CTRL write in the same cycle as an FSM clear of EN: the written value wins.
//  - STATUS W1C in the same cycle as EXPIRE entry: set wins, pending stays 1.
//  - COUNT never wraps below 0. CNT_W-bit unsigned arithmetic; wdata is truncated to CNT_W.
// CONFIGURATION
//  TIMER_PRESCALE_EN defined:
//   - CTRL[15:8] = P is R/W. An 8-bit prescale counter clears in LOAD.
//   - Tick fires when the prescale counter == P, then the counter wraps to 0.
//   - COUNT decrements every P+1 clks.
//  TIMER_PRESCALE_EN undefined: CTRL[15:8] reads 0, writes ignored; tick every clk.
// STRUCTURE
//  - Package timer_pkg holds:
//    - FSM state enum and MODE encodings
//    - register offsets (CTRL/PRESET/COUNT/STATUS)
//    - CTRL bit positions
//  - Sub-module timer_channel: one channel's registers, FSM and prescaler.
//    Instantiated NUM_CH times via generate.
//  - The top holds address decode, the read mux, and the irq_any reduction.
// TESTING
//  1. Reset=0 mid-count, PRESET=9 -> all registers 0, irq=0 immediately; no IRQ after release.
//  2. Ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) at e0 -> irq[0]=1 at e0+7.
//     CTRL.EN then reads 0; COUNT=0.
//  3. Ch1 PRESET=3, CTRL=0xB (auto-reload) -> pending sets every 6 clks.
//     W1C STATUS clears irq[1] next edge; set wins on a coincident expire.
//  4. IM=0, PRESET=2 -> STATUS.pending=1 while irq=0. Setting IM=1 raises irq the next cycle.
//  5. Address decode:
//     - addr=0x20 with NUM_CH=2: read 0, write has no effect.
//     - COUNT write is ignored.
//     - PRESET write mid-count does not change the current run.
//  6. TIMER_PRESCALE_EN, P=3, PRESET=2, one-shot -> COUNT steps every 4 clks.
//     Without the macro, CTRL[15:8] reads 0.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared FSM states, MODE encodings, register offsets and CTRL bit
// positions for the timer bank.
package timer_pkg;

    // Per-channel run state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_CNT    = 2'd2,
        ST_EXPIRE = 2'd3
    } timer_state_t;

    // CTRL.MODE encodings; 2'b1x behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // Register byte offsets within a channel's 0x10 window
    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_PRESET = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    // CTRL / STATUS bit positions
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_MODE_LSB   = 1;
    localparam int unsigned CTRL_IM_BIT     = 3;
    localparam int unsigned CTRL_PSC_LSB    = 8;
    localparam int unsigned STATUS_PEND_BIT = 0;

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counter channel -- registers, run FSM and optional
// prescaler. Optional feature macro: TIMER_PRESCALE_EN (CTRL[15:8] prescale).
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_ctrl,
    input  logic        wr_preset,
    input  logic        wr_status,
    input  logic [31:0] wdata,
    output logic [31:0] ctrl_rd,
    output logic [31:0] preset_rd,
    output logic [31:0] count_rd,
    output logic [31:0] status_rd,
    output logic        irq
);

    timer_state_t     state;
    logic             en;
    logic             im;
    logic             pending;
    logic [1:0]       mode;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             en_eff;
    logic             tick;
    logic             expire_set;
    logic             unused_wdata;

`ifdef TIMER_PRESCALE_EN
    logic [7:0] psc_div;
    logic [7:0] psc_cnt;

    // Tick when the prescale counter reaches the programmed divider
    always_comb tick = (psc_cnt == psc_div);
`else
    // Without prescaling every clock is a tick
    always_comb tick = 1'b1;
`endif

    // A CTRL write in this cycle decides EN, so the FSM sees the written value
    always_comb begin
        en_eff     = wr_ctrl ? wdata[CTRL_EN_BIT] : en;
        expire_set = en_eff && (state == ST_CNT) && (count == '0);
    end

    // Registers and run FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            en      <= 1'b0;
            mode    <= MODE_ONESHOT;
            im      <= 1'b0;
            preset  <= '0;
            count   <= '0;
            pending <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            psc_div <= '0;
            psc_cnt <= '0;
`endif
        end else begin
            if (wr_ctrl) begin
                en   <= wdata[CTRL_EN_BIT];
                mode <= wdata[CTRL_MODE_LSB +: 2];
                im   <= wdata[CTRL_IM_BIT];
`ifdef TIMER_PRESCALE_EN
                psc_div <= wdata[CTRL_PSC_LSB +: 8];
`endif
            end
            if (wr_preset) begin
                preset <= wdata[CNT_W-1:0];
            end
            if (expire_set) begin
                pending <= 1'b1;
            end else if (wr_status && wdata[STATUS_PEND_BIT]) begin
                pending <= 1'b0;
            end

            if (!en_eff) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_LOAD;
                    ST_LOAD: begin
                        count <= preset;
                        state <= ST_CNT;
`ifdef TIMER_PRESCALE_EN
                        psc_cnt <= '0;
`endif
                    end
                    ST_CNT: begin
                        if (count == '0) begin
                            state <= ST_EXPIRE;
                        end else begin
                            if (tick) begin
                                count <= count - CNT_W'(1);
                            end
`ifdef TIMER_PRESCALE_EN
                            psc_cnt <= tick ? 8'd0 : psc_cnt + 8'd1;
`endif
                        end
                    end
                    ST_EXPIRE: begin
                        if (mode == MODE_RELOAD) begin
                            state <= ST_LOAD;
                        end else begin
                            state <= ST_IDLE;
                            if (!wr_ctrl) begin
                                en <= 1'b0;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Register read views and masked interrupt
    always_comb begin
        ctrl_rd                         = '0;
        ctrl_rd[CTRL_EN_BIT]            = en;
        ctrl_rd[CTRL_MODE_LSB +: 2]     = mode;
        ctrl_rd[CTRL_IM_BIT]            = im;
`ifdef TIMER_PRESCALE_EN
        ctrl_rd[CTRL_PSC_LSB +: 8]      = psc_div;
`else
        ctrl_rd[CTRL_PSC_LSB +: 8]      = 8'd0;
`endif
        preset_rd                       = 32'(preset);
        count_rd                        = 32'(count);
        status_rd                       = '0;
        status_rd[STATUS_PEND_BIT]      = pending;
        irq                             = pending & im;
    end

    assign unused_wdata = ^wdata;

endmodule

// File: rtl/timer_bank.sv
// timer_bank: NUM_CH programmable down-counter timers on the peripheral bus.
// Top holds address decode, read mux and irq_any. Optional feature macro:
// TIMER_PRESCALE_EN (per-channel CTRL[15:8] clock prescaler).
module timer_bank
    import timer_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned AW     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);

    localparam int unsigned CHW        = AW - 4;
    localparam logic [1:0]  SEL_CTRL   = OFF_CTRL[3:2];
    localparam logic [1:0]  SEL_PRESET = OFF_PRESET[3:2];
    localparam logic [1:0]  SEL_COUNT  = OFF_COUNT[3:2];
    localparam logic [1:0]  SEL_STATUS = OFF_STATUS[3:2];

    logic [CHW-1:0] ch_idx;
    logic [1:0]     reg_sel;
    logic [31:0]    ctrl_rd   [NUM_CH];
    logic [31:0]    preset_rd [NUM_CH];
    logic [31:0]    count_rd  [NUM_CH];
    logic [31:0]    status_rd [NUM_CH];
    logic           unused_addr;

    assign ch_idx      = addr[AW-1:4];
    assign reg_sel     = addr[3:2];
    assign unused_addr = ^addr[1:0];

    // One channel per index; writes outside 0..NUM_CH-1 select nobody
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic hit;
        assign hit = we && (32'(ch_idx) == 32'(g));

        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_ctrl   (hit && (reg_sel == SEL_CTRL)),
            .wr_preset (hit && (reg_sel == SEL_PRESET)),
            .wr_status (hit && (reg_sel == SEL_STATUS)),
            .wdata     (wdata),
            .ctrl_rd   (ctrl_rd[g]),
            .preset_rd (preset_rd[g]),
            .count_rd  (count_rd[g]),
            .status_rd (status_rd[g]),
            .irq       (irq[g])
        );
    end

    // Combinational read mux; unmapped channels read 0
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (32'(ch_idx) == i) begin
                case (reg_sel)
                    SEL_CTRL:   rdata = ctrl_rd[i];
                    SEL_PRESET: rdata = preset_rd[i];
                    SEL_COUNT:  rdata = count_rd[i];
                    default:    rdata = status_rd[i];
                endcase
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed scenarios plus randomized bus traffic, checked every
// cycle against a timestamp-based behavioural model of the timer bank.
module tb_timer_bank;

    localparam int NCH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  irq;
    logic        irq_any;

    int checks = 0;
    int errors = 0;

    timer_bank #(.NUM_CH(2), .CNT_W(32), .AW(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq),
        .irq_any (irq_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel is described by edge timestamps of its
    // next load, its expiry and the post-expiry decision.
    bit        m_en   [NCH];
    bit [1:0]  m_mode [NCH];
    bit        m_im   [NCH];
    bit [31:0] m_preset [NCH];
    bit [31:0] m_count  [NCH];
    bit        m_pend [NCH];
    bit        m_idle [NCH];
    longint    m_load_at [NCH];
    longint    m_exp_at  [NCH];
    longint    m_dec_at  [NCH];
    longint    m_lstart  [NCH];
    longint    m_lp      [NCH];
    longint    m_t = 0;

    always @(posedge clk or negedge reset) begin
        bit        wc, wp, ws, eff_en, exp_now;
        bit [31:0] old_p;
        bit [1:0]  old_m;
        longint    t;
        if (!reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_mode[c] = 0; m_im[c] = 0; m_preset[c] = 0;
                m_count[c] = 0; m_pend[c] = 0; m_idle[c] = 1;
                m_load_at[c] = -1; m_exp_at[c] = -1; m_dec_at[c] = -1;
                m_lstart[c] = 0; m_lp[c] = 0;
            end
        end else begin
            m_t++;
            t = m_t;
            for (int c = 0; c < NCH; c++) begin
                wc = we && int'(addr[7:4]) == c && addr[3:2] == 2'd0;
                wp = we && int'(addr[7:4]) == c && addr[3:2] == 2'd1;
                ws = we && int'(addr[7:4]) == c && addr[3:2] == 2'd3;
                eff_en  = wc ? wdata[0] : m_en[c];
                exp_now = eff_en && (m_exp_at[c] == t);
                old_p = m_preset[c];
                old_m = m_mode[c];
                if (wc) begin
                    m_en[c] = wdata[0]; m_mode[c] = wdata[2:1]; m_im[c] = wdata[3];
                end
                if (wp) m_preset[c] = wdata;
                if (exp_now) m_pend[c] = 1;
                else if (ws && wdata[0]) m_pend[c] = 0;

                if (!eff_en) begin
                    m_idle[c] = 1; m_load_at[c] = -1; m_exp_at[c] = -1; m_dec_at[c] = -1;
                end else if (m_idle[c]) begin
                    m_idle[c] = 0; m_load_at[c] = t + 1;
                end else if (m_load_at[c] == t) begin
                    m_load_at[c] = -1;
                    m_lstart[c]  = t;
                    m_lp[c]      = longint'(old_p);
                    m_count[c]   = old_p;
                    m_exp_at[c]  = t + longint'(old_p) + 1;
                end else if (exp_now) begin
                    m_exp_at[c] = -1; m_dec_at[c] = t + 1;
                end else if (m_dec_at[c] == t) begin
                    m_dec_at[c] = -1;
                    if (old_m == 2'b01) m_load_at[c] = t + 1;
                    else begin
                        m_idle[c] = 1;
                        if (!wc) m_en[c] = 0;
                    end
                end else begin
                    m_count[c] = 32'(m_lp[c] - (t - m_lstart[c]));
                end
            end
        end
    end

    function automatic logic [31:0] model_rd(input logic [7:0] a);
        int ch;
        ch = int'(a[7:4]);
        if (ch >= NCH) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, m_im[ch], m_mode[ch], m_en[ch]};
            2'd1:    return m_preset[ch];
            2'd2:    return m_count[ch];
            default: return {31'd0, m_pend[ch]};
        endcase
    endfunction

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic [1:0] ei;
        ei = {m_pend[1] & m_im[1], m_pend[0] & m_im[0]};
        chk("rdata", rdata, model_rd(addr));
        chk("irq", 32'(irq), 32'(ei));
        chk("irq_any", 32'(irq_any), 32'(|ei));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drive a write now; it takes effect at the next rising edge
    task automatic wr(input int ch, input int off, input logic [31:0] d);
        addr  = 8'(ch * 16 + off);
        we    = 1'b1;
        wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic peek(input int ch, input int off, input logic [31:0] exp, input string name);
        addr = 8'(ch * 16 + off);
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic wait_until(input longint e);
        while (m_t < e) step();
    endtask

    initial begin
        longint e0;
        int r, ch, rg;
        logic [31:0] d;

        reset = 1'b0; addr = '0; we = 1'b0; wdata = '0;
        repeat (3) step();
        peek(0, 8, 32'd0, "reset_count");
        chk("reset_irq", 32'(irq), 32'd0);
        reset = 1'b1;
        step();

        // One-shot, PRESET=5: interrupt 7 edges after the CTRL write
        wr(0, 4, 32'd5);
        wr(0, 0, 32'h9);
        e0 = m_t;
        wait_until(e0 + 6); chk("os_irq_early", 32'(irq[0]), 32'd0);
        wait_until(e0 + 7); chk("os_irq", 32'(irq[0]), 32'd1);
        peek(0, 8, 32'd0, "os_count_zero");
        wait_until(e0 + 8); peek(0, 0, 32'h8, "os_en_cleared");
        wr(0, 12, 32'd1);
        peek(0, 12, 32'd0, "os_w1c");

        // Auto-reload, PRESET=3: expiries at e0+5, e0+11, e0+17
        wr(1, 4, 32'd3);
        wr(1, 0, 32'hB);
        e0 = m_t;
        wait_until(e0 + 4); chk("ar_before", 32'(irq[1]), 32'd0);
        wait_until(e0 + 5); chk("ar_first", 32'(irq[1]), 32'd1);
        wr(1, 12, 32'd1);   chk("ar_w1c", 32'(irq[1]), 32'd0);
        wait_until(e0 + 10);
        wr(1, 12, 32'd1);   chk("ar_set_wins", 32'(irq[1]), 32'd1);
        wr(1, 12, 32'd1);   chk("ar_w1c2", 32'(irq[1]), 32'd0);
        wait_until(e0 + 16); chk("ar_period_early", 32'(irq[1]), 32'd0);
        wait_until(e0 + 17); chk("ar_period", 32'(irq[1]), 32'd1);
        wr(1, 0, 32'd0);
        wr(1, 12, 32'd1);

        // Masked interrupt, then unmask
        wr(0, 4, 32'd2);
        wr(0, 0, 32'h1);
        e0 = m_t;
        wait_until(e0 + 4);
        peek(0, 12, 32'd1, "im0_pending");
        chk("im0_irq", 32'(irq[0]), 32'd0);
        wr(0, 0, 32'h8);    chk("im1_irq", 32'(irq[0]), 32'd1);
        wr(0, 12, 32'd1);   chk("im1_clear", 32'(irq[0]), 32'd0);

        // Unmapped channel, ignored COUNT write, mid-run PRESET write
        wr(2, 0, 32'hFFFF_FFFF);
        wr(2, 4, 32'hFFFF_FFFF);
        peek(2, 0, 32'd0, "bad_ch_ctrl");
        peek(2, 4, 32'd0, "bad_ch_preset");
        wr(0, 4, 32'd20);
        wr(0, 0, 32'h9);
        e0 = m_t;
        wait_until(e0 + 5); peek(0, 8, 32'd16, "count_run");
        wr(0, 8, 32'h55);   peek(0, 8, 32'd15, "count_wr_ignored");
        wr(0, 4, 32'd3);    peek(0, 8, 32'd14, "preset_midrun");
        wait_until(e0 + 21); chk("preset_midrun_early", 32'(irq[0]), 32'd0);
        wait_until(e0 + 22); chk("preset_midrun_expire", 32'(irq[0]), 32'd1);
        wr(0, 12, 32'd1);

        // Default build: CTRL prescale field reads 0
        wr(1, 0, 32'h0000_FF00);
        peek(1, 0, 32'd0, "psc_reads_zero");

        // Randomized bus traffic
        repeat (3000) begin
            r  = int'($urandom_range(0, 9));
            ch = (r < 4) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : int'($urandom_range(0, 15));
            rg = int'($urandom_range(0, 3));
            d  = $urandom;
            if (rg == 1 && $urandom_range(0, 7) != 0) d = $urandom_range(0, 12);
            if (rg == 0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            addr  = 8'(ch * 16 + rg * 4 + int'($urandom_range(0, 3)));
            wdata = d;
            we    = ($urandom_range(0, 5) == 0);
            step();
        end
        we = 1'b0;

        // Asynchronous reset in the middle of a count
        wr(0, 4, 32'd9);
        wr(0, 0, 32'h9);
        repeat (4) step();
        addr  = 8'h08;
        reset = 1'b0;
        #1;
        chk("rst_count", rdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_irq_any", 32'(irq_any), 32'd0);
        step();
        peek(0, 4, 32'd0, "rst_preset");
        peek(0, 0, 32'd0, "rst_ctrl");
        step();
        reset = 1'b1;
        repeat (15) step();
        chk("rst_no_irq", 32'(irq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
